// File: rtl/video_timing_gen_param.sv
// video_timing_gen_param: parametrised raster timing with syncs, line/frame pulses,
// frame counter, clock-enable stall and a lead-ahead fetch coordinate.
module video_timing_gen_param #(
   parameter int H_ACTIVE = 1280,
   parameter int H_FP     = 110,
   parameter int H_SYNC   = 40,
   parameter int H_BP     = 220,
   parameter int V_ACTIVE = 720,
   parameter int V_FP     = 5,
   parameter int V_SYNC   = 5,
   parameter int V_BP     = 20,
   parameter bit HS_POL   = 1'b1,
   parameter bit VS_POL   = 1'b1,
   parameter int FC_MAX   = 60,
   parameter int LEAD     = 2,
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int HW      = $clog2(H_TOTAL),
   localparam int VW      = $clog2(V_TOTAL),
   localparam int FW      = $clog2(FC_MAX)
) (
   input  logic          clk_pixel_in,
   input  logic          rst_in,
   input  logic          en_in,
   output logic [HW-1:0] hcount_out,
   output logic [VW-1:0] vcount_out,
   output logic          hs_out,
   output logic          vs_out,
   output logic          ad_out,
   output logic          nl_out,
   output logic          nf_out,
   output logic [FW-1:0] fc_out,
   output logic [HW-1:0] fetch_x_out,
   output logic [VW-1:0] fetch_y_out,
   output logic          fetch_valid_out
);
   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [HW-1:0] F_RST  = HW'(LEAD - 1);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [FW-1:0] FC_LAST = FW'(FC_MAX - 1);

   logic [HW-1:0] h_nx, fx_nx;
   logic [VW-1:0] v_nx, fy_nx;
   logic          nf_hit;

   // All registered outputs are derived from the position being entered, keeping them aligned.
   always_comb begin
      h_nx   = (hcount_out == H_LAST) ? '0 : hcount_out + 1'b1;
      v_nx   = (hcount_out != H_LAST) ? vcount_out : (vcount_out == V_LAST) ? '0 : vcount_out + 1'b1;
      fx_nx  = (fetch_x_out == H_LAST) ? '0 : fetch_x_out + 1'b1;
      fy_nx  = (fetch_x_out != H_LAST) ? fetch_y_out : (fetch_y_out == V_LAST) ? '0 : fetch_y_out + 1'b1;
      nf_hit = (h_nx == H_ACT) && (v_nx == V_ACT);
   end

   always_ff @(posedge clk_pixel_in or negedge rst_in) begin
      if (!rst_in) begin
         hcount_out      <= H_LAST;
         vcount_out      <= V_LAST;
         hs_out          <= !HS_POL;
         vs_out          <= !VS_POL;
         ad_out          <= 1'b0;
         nl_out          <= 1'b0;
         nf_out          <= 1'b0;
         fc_out          <= '0;
         fetch_x_out     <= F_RST;
         fetch_y_out     <= '0;
         fetch_valid_out <= 1'b1;
      end else begin
         nl_out <= en_in && (h_nx == '0);
         nf_out <= en_in && nf_hit;
         if (en_in) begin
            hcount_out      <= h_nx;
            vcount_out      <= v_nx;
            hs_out          <= (h_nx >= HS_BEG && h_nx < HS_END) ? HS_POL : !HS_POL;
            vs_out          <= (v_nx >= VS_BEG && v_nx < VS_END) ? VS_POL : !VS_POL;
            ad_out          <= (h_nx < H_ACT) && (v_nx < V_ACT);
            fc_out          <= !nf_hit ? fc_out : (fc_out == FC_LAST) ? '0 : fc_out + 1'b1;
            fetch_x_out     <= fx_nx;
            fetch_y_out     <= fy_nx;
            fetch_valid_out <= (fx_nx < H_ACT) && (fy_nx < V_ACT);
         end
      end
   end
endmodule

// File: tb/tb_video_timing_gen_param.sv
// tb_video_timing_gen_param: scoreboard bench for a small and a default-sized timing generator,
// predicting outputs from a linear raster index model.
module tb_video_timing_gen_param;
   typedef struct packed { int ha, hfp, hsy, hbp, va, vfp, vsy, vbp, fcm, lead; bit hp, vp; } cfg_t;
   typedef struct packed { int h, v, fx, fy, fc; bit hs, vs, ad, nl, nf, fv; } out_t;

   localparam cfg_t CS = '{8, 2, 2, 2, 4, 1, 1, 1, 3, 3, 1'b1, 1'b1};
   localparam cfg_t CD = '{1280, 110, 40, 220, 720, 5, 5, 20, 60, 2, 1'b1, 1'b1};

   logic clk = 1'b0, rst = 1'b0, en = 1'b0;
   logic [3:0]  s_h, s_fx;
   logic [2:0]  s_v, s_fy;
   logic [1:0]  s_fc;
   logic        s_hs, s_vs, s_ad, s_nl, s_nf, s_fv;
   logic [10:0] d_h, d_fx;
   logic [9:0]  d_v, d_fy;
   logic [5:0]  d_fc;
   logic        d_hs, d_vs, d_ad, d_nl, d_nf, d_fv;

   always #5 clk = ~clk;

   video_timing_gen_param #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
      .V_SYNC(1), .V_BP(1), .FC_MAX(3), .LEAD(3)) u_s (
      .clk_pixel_in(clk), .rst_in(rst), .en_in(en), .hcount_out(s_h), .vcount_out(s_v),
      .hs_out(s_hs), .vs_out(s_vs), .ad_out(s_ad), .nl_out(s_nl), .nf_out(s_nf), .fc_out(s_fc),
      .fetch_x_out(s_fx), .fetch_y_out(s_fy), .fetch_valid_out(s_fv));

   video_timing_gen_param u_d (
      .clk_pixel_in(clk), .rst_in(rst), .en_in(en), .hcount_out(d_h), .vcount_out(d_v),
      .hs_out(d_hs), .vs_out(d_vs), .ad_out(d_ad), .nl_out(d_nl), .nf_out(d_nf), .fc_out(d_fc),
      .fetch_x_out(d_fx), .fetch_y_out(d_fy), .fetch_valid_out(d_fv));

   int total = 0, bad = 0;
   out_t qs[$], qd[$];
   longint pos_s = -1, pos_d = -1;
   int fc_s = 0, fc_d = 0;
   bit nl_s, nf_s, nl_d, nf_d, rec;
   out_t cur_s, cur_d;
   int cyc = 0, hs_cnt = 0, hs_min = 99999, hs_max = -1;
   int fc_seen[$], nl_times[$];

   // Reference: the raster is a single linear index; pos = -1 is the reset position (last pixel).
   function automatic out_t view(cfg_t c, longint pos, int fc, bit nl, bit nf);
      out_t o;
      longint ht, vt, tot, p, q;
      ht = c.ha + c.hfp + c.hsy + c.hbp;
      vt = c.va + c.vfp + c.vsy + c.vbp;
      tot = ht * vt;
      p = ((pos % tot) + tot) % tot;
      q = (p + c.lead) % tot;
      o.h = int'(p % ht);
      o.v = int'(p / ht);
      o.fx = int'(q % ht);
      o.fy = int'(q / ht);
      o.ad = o.h < c.ha && o.v < c.va;
      o.hs = (o.h >= c.ha + c.hfp && o.h < c.ha + c.hfp + c.hsy) ? c.hp : !c.hp;
      o.vs = (o.v >= c.va + c.vfp && o.v < c.va + c.vfp + c.vsy) ? c.vp : !c.vp;
      o.fv = o.fx < c.ha && o.fy < c.va;
      o.fc = fc;
      o.nl = nl;
      o.nf = nf;
      return o;
   endfunction

   task automatic step(input cfg_t c, input bit r, input bit e, inout longint pos, inout int fc,
                       inout bit nl, inout bit nf);
      out_t o;
      if (!r) begin
         pos = -1; fc = 0; nl = 0; nf = 0;
      end else if (e) begin
         pos++;
         o = view(c, pos, 0, 0, 0);
         nl = o.h == 0;
         nf = o.h == c.ha && o.v == c.va;
         if (nf) fc = (fc + 1) % c.fcm;
      end else begin
         nl = 0; nf = 0;
      end
   endtask

   function automatic out_t get_s();
      out_t o;
      o = '{int'(s_h), int'(s_v), int'(s_fx), int'(s_fy), int'(s_fc), s_hs, s_vs, s_ad, s_nl, s_nf, s_fv};
      return o;
   endfunction

   function automatic out_t get_d();
      out_t o;
      o = '{int'(d_h), int'(d_v), int'(d_fx), int'(d_fy), int'(d_fc), d_hs, d_vs, d_ad, d_nl, d_nf, d_fv};
      return o;
   endfunction

   function automatic string fmt(out_t o);
      return $sformatf("h=%0d v=%0d hs=%0b vs=%0b ad=%0b nl=%0b nf=%0b fc=%0d fx=%0d fy=%0d fv=%0b",
                       o.h, o.v, o.hs, o.vs, o.ad, o.nl, o.nf, o.fc, o.fx, o.fy, o.fv);
   endfunction

   task automatic check(input string name, input out_t got, input out_t exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s @%0t got {%s} want {%s}", name, $time, fmt(got), fmt(exp));
      end
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", name, got, exp);
      end
   endtask

   // Drive one edge's inputs and queue the outputs that edge must produce.
   task automatic cycle(input bit r, input bit e);
      @(negedge clk);
      rst = r;
      en = e;
      step(CS, r, e, pos_s, fc_s, nl_s, nf_s);
      step(CD, r, e, pos_d, fc_d, nl_d, nf_d);
      cur_s = view(CS, pos_s, fc_s, nl_s, nf_s);
      cur_d = view(CD, pos_d, fc_d, nl_d, nf_d);
      qs.push_back(cur_s);
      qd.push_back(cur_d);
      if (!r) begin
         #1;
         check("async_rst_small", get_s(), cur_s);
         check("async_rst_dflt", get_d(), cur_d);
      end
   endtask

   initial forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (qs.size() > 0) check("sb_small", get_s(), qs.pop_front());
      if (qd.size() > 0) check("sb_dflt", get_d(), qd.pop_front());
      if (rec && s_nf) fc_seen.push_back(int'(s_fc));
      if (rec && d_nl) nl_times.push_back(cyc);
      if (rec && d_v == 0 && d_hs) begin
         hs_cnt++;
         if (int'(d_h) < hs_min) hs_min = int'(d_h);
         if (int'(d_h) > hs_max) hs_max = int'(d_h);
      end
   end

   initial begin
      int exp_fc[7] = '{1, 2, 0, 1, 2, 0, 1};
      repeat (3) cycle(1'b0, 1'b1);
      check_int("rst_small_h", int'(s_h), 13);
      check_int("rst_small_v", int'(s_v), 6);
      check_int("rst_small_fx", int'(s_fx), 2);
      check_int("rst_small_fy", int'(s_fy), 0);
      check_int("rst_dflt_h", int'(d_h), 1649);
      check_int("rst_dflt_v", int'(d_v), 749);
      check_int("rst_dflt_ad", int'(d_ad), 0);
      rec = 1'b1;
      cycle(1'b1, 1'b1);
      @(posedge clk);
      #2;
      check_int("first_h", int'(d_h), 0);
      check_int("first_ad", int'(d_ad), 1);
      check_int("first_fx", int'(d_fx), 2);
      check_int("first_fv", int'(d_fv), 1);
      repeat (1700) cycle(1'b1, 1'b1);
      rec = 1'b0;
      do cycle(1'b1, 1'b1); while (!nf_s);
      repeat (5) cycle(1'b1, 1'b0);
      do cycle(1'b1, 1'b1); while (cur_s.h != 4);
      repeat (5) cycle(1'b1, 1'b0);
      repeat (50) cycle(1'b1, 1'b1);
      do cycle(1'b1, 1'b1); while (!(cur_s.h == 5 && cur_s.v == 2));
      cycle(1'b0, 1'b1);
      repeat (200) cycle(1'b1, 1'b1);
      repeat (1500) cycle($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0);
      @(posedge clk);
      #3;
      for (int i = 0; i < 7; i++)
         check_int($sformatf("fc_seq%0d", i), (i < fc_seen.size()) ? fc_seen[i] : -1, exp_fc[i]);
      check_int("hs_width", hs_cnt, 40);
      check_int("hs_first", hs_min, 1390);
      check_int("hs_last", hs_max, 1429);
      check_int("line_len", (nl_times.size() >= 2) ? nl_times[1] - nl_times[0] : -1, 1650);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
